// File: rtl/mux_arb_pkg.sv
// Shared types and arbitration helpers for the 4-channel round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Round-robin search: first asserted request in the order last+1, last+2,
  // last+3, last (all modulo NUM_REQ). The loop runs from lowest to highest
  // priority so the highest-priority hit is the last one written.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   last);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  // Fixed priority search: req[0] highest, req[NUM_REQ-1] lowest.
  function automatic pick_t fp_pick(input logic [NUM_REQ-1:0] req);
    pick_t p;
    p.found = 1'b0;
    p.idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        p.found = 1'b1;
        p.idx   = SEL_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_4x1_nbit.sv
// Plain combinational 4:1 mux of N-bit words, selected by a 2-bit select.
module mux_4x1_nbit #(
  parameter int N = 3
) (
  input  logic [1:0]   s,
  input  logic [N-1:0] w0,
  input  logic [N-1:0] w1,
  input  logic [N-1:0] w2,
  input  logic [N-1:0] w3,
  output logic [N-1:0] f
);

  // Route the selected word to the output.
  always_comb begin
    f = w0;
    unique case (s)
      2'd0:    f = w0;
      2'd1:    f = w1;
      2'd2:    f = w2;
      2'd3:    f = w3;
      default: f = w0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter_4ch.sv
// Round-robin arbiter/sequencer sharing one N-bit channel between four
// requesters. One transfer per grant; valid/ready handshake on the output.
// Optional build macro MUX_ARB_FIXED_PRIORITY_EN replaces round-robin with
// fixed priority (req[0] highest) and removes the last-winner pointer.
module mux_rr_arbiter_4ch
  import mux_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [N-1:0]       w0,
  input  logic [N-1:0]       w1,
  input  logic [N-1:0]       w2,
  input  logic [N-1:0]       w3,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [N-1:0]       f,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   s
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   s_q, s_d;
  pick_t              pick;

`ifdef MUX_ARB_FIXED_PRIORITY_EN
  // Winner selection with static priority; no history kept.
  always_comb begin
    pick = fp_pick(req);
  end
`else
  logic [SEL_W-1:0] last_q, last_d;

  // Winner selection starting just after the most recently served requester.
  always_comb begin
    pick = rr_pick(req, last_q);
  end

  // Last-winner pointer; reset to 3 so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= SEL_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state logic: grant on any request in IDLE; in GRANT leave on a
  // completed transfer (which wins over a simultaneous withdrawal) or on
  // withdrawal of the granted request while the consumer is stalled.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          gnt_d   = 4'b0001 << pick.idx;
          s_d     = pick.idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ready) begin
`ifndef MUX_ARB_FIXED_PRIORITY_EN
          last_d  = s_q;
`endif
          gnt_d   = '0;
          state_d = IDLE;
        end else if (!req[s_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: state, one-hot grant and encoded mux select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
    end
  end

  assign gnt       = gnt_q;
  assign s         = s_q;
  assign out_valid = (state_q == GRANT);

  mux_4x1_nbit #(
    .N(N)
  ) u_mux (
    .s (s_q),
    .w0(w0),
    .w1(w1),
    .w2(w2),
    .w3(w3),
    .f (f)
  );

endmodule
